seg_disp_sched: RTL and testbench
=================================

SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

Interface
REQ-001 Parameter HOLD_MAX, default 26'd49_999_999, minimum grant hold in sys_clk cycles minus one (1 s at 50 MHz).
REQ-002 Parameter BLANK_MAX, default 20'd999_999, blank gap between grants in cycles minus one (20 ms).
REQ-003 sys_clk  input  1  system clock, all logic rising-edge.
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  3  per-source display request, bit i = source i, level-sensitive.
REQ-006 data0/data1/data2  input  20  per-source value to display, 0..999999.
REQ-007 point0/point1/point2  input  6  per-source decimal-point mask.
REQ-008 sign0/sign1/sign2  input  1  per-source minus-sign flag.
REQ-009 data  output  20  value forwarded to seg_dynamic.
REQ-010 point  output  6  point mask forwarded to seg_dynamic.
REQ-011 sign  output  1  sign flag forwarded to seg_dynamic.
REQ-012 seg_en  output  1  display enable forwarded to seg_dynamic.
REQ-013 grant  output  3  one-hot owner of the display; 3'b000 when none.

Function
REQ-014 FSM states IDLE, SHOW, BLANK; all outputs registered.
REQ-015 IDLE: seg_en=0, grant=0, data=0, point=0, sign=0; any req bit high -> SHOW on next edge.
REQ-016 Entry to SHOW: winner picked round-robin, search order last+1, last+2, last (mod 3); last updated to winner; grant, seg_en=1 and outputs valid on the same edge (1-cycle latency from req).
REQ-017 SHOW: data/point/sign track the granted source every cycle (registered, 1-cycle delay), so a live source updates the display.
REQ-018 SHOW: hold counter increments from 0 each cycle, saturates at HOLD_MAX.
REQ-019 SHOW, counter==HOLD_MAX and any other req bit high -> BLANK.
REQ-020 SHOW, counter==HOLD_MAX, no other req, own req high -> remain in SHOW, counter held.
REQ-021 SHOW, own req low (any counter value): other req high -> BLANK, else -> IDLE.
REQ-022 BLANK: seg_en=0, grant=0, data/point/sign=0; blank counter 0..BLANK_MAX; at BLANK_MAX: any req -> SHOW (REQ-016 arbitration), else IDLE.
REQ-023 Requests asserting or dropping during BLANK only matter at its final cycle; no early exit.
REQ-024 Counters cleared on every state entry; no wrap beyond saturation.
REQ-025 grant always one-hot or zero; seg_en==|grant in every cycle.

Reset
REQ-026 sys_rst_n low: state=IDLE, both counters=0, last=2 (first search order 0,1,2), all outputs 0, immediately and asynchronously.
REQ-027 Reset mid-SHOW or mid-BLANK drops seg_en and grant in the same instant; after release operation restarts from IDLE.

Structure
REQ-028 No shared package; state encoding and index constants are localparams inside the module; HOLD_MAX/BLANK_MAX overridable via defparam for simulation.
REQ-029 One sub-module: seg_rr_pick, combinational 3-way round-robin picker (req, last -> one-hot winner, valid); seg_dynamic is instantiated by the parent, not inside this block.

Verification (HOLD_MAX=5, BLANK_MAX=2)
REQ-030 Reset, req=3'b001, data0=9876, point0=6'b000010, sign0=1 -> next edge grant=001, seg_en=1, data=9876, point=000010, sign=1; held indefinitely.
REQ-031 req=3'b011 from IDLE -> grant 001 for 6 cycles, 3 cycles seg_en=0, grant 010 for 6 cycles, blank, grant 001 again.
REQ-032 req=3'b111 steady -> grant sequence 001,010,100,001 with 3-cycle blanks; seg_en==|grant throughout.
REQ-033 Source 0 granted, data0 stepping 0,1,2 each cycle -> data follows with 1-cycle delay while in SHOW.
REQ-034 req drops to 0 at hold count 2 -> IDLE next edge, seg_en=0, data=0; req=3'b100 then -> grant 100.
REQ-035 sys_rst_n pulsed low mid-SHOW -> grant=0, seg_en=0 asynchronously; after release with req=3'b110 -> grant 010 first.

Source files
------------

// File: rtl/seg_rr_pick.sv
// Combinational 3-way round-robin picker: searches last+1, last+2, last (mod 3)
// and returns the one-hot winner plus a valid flag.
module seg_rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    win   = 3'b000;
    valid = |req;
    case (last)
      2'd0: begin
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd1: begin
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Time-shares one seven-segment display between three sources: each grant is
// held for at least HOLD_MAX+1 cycles, separated by a blank gap of BLANK_MAX+1 cycles.
module seg_disp_sched #(
  parameter logic [25:0] HOLD_MAX  = 26'd49_999_999,
  parameter logic [19:0] BLANK_MAX = 20'd999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  input  logic [5:0]  point0,
  input  logic [5:0]  point1,
  input  logic [5:0]  point2,
  input  logic        sign0,
  input  logic        sign1,
  input  logic        sign2,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic [2:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [1:0] IDX0       = 2'd0;
  localparam logic [1:0] IDX1       = 2'd1;
  localparam logic [1:0] IDX2       = 2'd2;
  localparam logic [1:0] LAST_RESET = IDX2;

  state_t      state;
  logic [25:0] hold_cnt;
  logic [19:0] blank_cnt;
  logic [1:0]  last;

  logic [2:0]  win;
  logic        valid;
  logic [1:0]  win_idx;
  logic [1:0]  sel_idx;
  logic [19:0] sel_data;
  logic [5:0]  sel_point;
  logic        sel_sign;
  logic        own_req;
  logic        other_req;

  seg_rr_pick u_pick (
    .req   (req),
    .last  (last),
    .win   (win),
    .valid (valid)
  );

  always_comb begin
    win_idx = IDX0;
    if      (win[1]) win_idx = IDX1;
    else if (win[2]) win_idx = IDX2;
  end

  // While showing, 'last' is the current owner; otherwise the fresh winner is loaded.
  always_comb begin
    sel_idx = (state == SHOW) ? last : win_idx;
    case (sel_idx)
      IDX0:    begin sel_data = data0; sel_point = point0; sel_sign = sign0; end
      IDX1:    begin sel_data = data1; sel_point = point1; sel_sign = sign1; end
      default: begin sel_data = data2; sel_point = point2; sel_sign = sign2; end
    endcase
  end

  assign own_req   = |(req & grant);
  assign other_req = |(req & ~grant);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // update in this block sees the pre-edge values, matching flop behaviour.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      blank_cnt <= '0;
      last      <= LAST_RESET;
      grant     <= 3'b000;
      seg_en    <= 1'b0;
      data      <= '0;
      point     <= '0;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            state    <= SHOW;
            hold_cnt <= '0;
            last     <= win_idx;
            grant    <= win;
            seg_en   <= 1'b1;
            data     <= sel_data;
            point    <= sel_point;
            sign     <= sel_sign;
          end
        end

        SHOW: begin
          if (!own_req || (hold_cnt == HOLD_MAX && other_req)) begin
            state     <= other_req ? BLANK : IDLE;
            blank_cnt <= '0;
            hold_cnt  <= '0;
            grant     <= 3'b000;
            seg_en    <= 1'b0;
            data      <= '0;
            point     <= '0;
            sign      <= 1'b0;
          end else begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 26'd1;
            data  <= sel_data;
            point <= sel_point;
            sign  <= sel_sign;
          end
        end

        BLANK: begin
          // Requests are only looked at on the final blank cycle.
          if (blank_cnt == BLANK_MAX) begin
            blank_cnt <= '0;
            if (valid) begin
              state    <= SHOW;
              hold_cnt <= '0;
              last     <= win_idx;
              grant    <= win;
              seg_en   <= 1'b1;
              data     <= sel_data;
              point    <= sel_point;
              sign     <= sel_sign;
            end else begin
              state <= IDLE;
            end
          end else begin
            blank_cnt <= blank_cnt + 20'd1;
          end
        end

        default: begin
          state     <= IDLE;
          hold_cnt  <= '0;
          blank_cnt <= '0;
          grant     <= 3'b000;
          seg_en    <= 1'b0;
          data      <= '0;
          point     <= '0;
          sign      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with HOLD_MAX=5, BLANK_MAX=2: expected
// display outputs are queued per cycle and compared after each rising edge.
module tb_seg_disp_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [2:0]  req;
  logic [19:0] data0, data1, data2;
  logic [5:0]  point0, point1, point2;
  logic        sign0, sign1, sign2;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [2:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [2:0]  grant;
    logic        seg_en;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
  } exp_t;

  exp_t sb[$];

  seg_disp_sched #(
    .HOLD_MAX  (26'd5),
    .BLANK_MAX (20'd2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .point0    (point0),
    .point1    (point1),
    .point2    (point2),
    .sign0     (sign0),
    .sign1     (sign1),
    .sign2     (sign2),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .grant     (grant)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected outputs for a given owner come from the source inputs as they are now.
  task automatic push_exp(input string tag, input logic [2:0] g);
    exp_t e;
    e.tag    = tag;
    e.grant  = g;
    e.seg_en = (g != 3'b000);
    e.data   = g[0] ? data0  : g[1] ? data1  : g[2] ? data2  : 20'd0;
    e.point  = g[0] ? point0 : g[1] ? point1 : g[2] ? point2 : 6'd0;
    e.sign   = g[0] ? sign0  : g[1] ? sign1  : g[2] ? sign2  : 1'b0;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    n_checks += 5;
    assert (grant === e.grant) else begin
      n_fail++; $error("FAIL %s grant: got %b want %b", e.tag, grant, e.grant);
    end
    assert (seg_en === e.seg_en) else begin
      n_fail++; $error("FAIL %s seg_en: got %b want %b", e.tag, seg_en, e.seg_en);
    end
    assert (data === e.data) else begin
      n_fail++; $error("FAIL %s data: got %0d want %0d", e.tag, data, e.data);
    end
    assert (point === e.point) else begin
      n_fail++; $error("FAIL %s point: got %b want %b", e.tag, point, e.point);
    end
    assert (sign === e.sign) else begin
      n_fail++; $error("FAIL %s sign: got %b want %b", e.tag, sign, e.sign);
    end
  endtask

  // One clock: queue the expectation, let the edge happen, compare 1 time unit later.
  task automatic tick(input string tag, input logic [2:0] g);
    push_exp(tag, g);
    @(posedge sys_clk);
    #1;
    compare_front();
  endtask

  task automatic ticks(input string tag, input int n, input logic [2:0] g);
    for (int i = 0; i < n; i++) tick(tag, g);
  endtask

  // Compare right now without a clock edge (asynchronous behaviour).
  task automatic check_now(input string tag, input logic [2:0] g);
    push_exp(tag, g);
    compare_front();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req    = 3'b000;
    data0  = 20'd9876;   point0 = 6'b000010; sign0 = 1'b1;
    data1  = 20'd111111; point1 = 6'b100000; sign1 = 1'b0;
    data2  = 20'd222;    point2 = 6'b000001; sign2 = 1'b1;

    #2;
    check_now("reset_state", 3'b000);
    @(posedge sys_clk); #1;
    check_now("reset_held", 3'b000);
    sys_rst_n = 1'b1;
    tick("idle_no_req", 3'b000);

    // Two requesters alternate with blank gaps; source 0 wins first after reset.
    req = 3'b011;
    ticks("rr2_show0", 6, 3'b001);
    ticks("rr2_blank_a", 3, 3'b000);
    ticks("rr2_show1", 6, 3'b010);
    ticks("rr2_blank_b", 3, 3'b000);
    tick("rr2_show0_again", 3'b001);

    // Single requester keeps the display past hold saturation; live data tracks.
    req = 3'b001;
    for (int i = 0; i < 8; i++) begin
      data0 = 20'(i);
      tick("live_data", 3'b001);
    end
    data0 = 20'd9876;
    ticks("hold_sat", 4, 3'b001);

    // Dropping the own request at hold count 2 returns to idle.
    req = 3'b000;
    tick("drop_to_idle", 3'b000);
    req = 3'b001;
    ticks("reenter_src0", 3, 3'b001);
    req = 3'b000;
    tick("drop_at_cnt2", 3'b000);
    req = 3'b100;
    tick("grant_src2", 3'b100);

    // All three requesting: full rotation with blanks in between.
    req = 3'b111;
    ticks("rr3_show2", 5, 3'b100);
    ticks("rr3_blank_a", 3, 3'b000);
    ticks("rr3_show0", 6, 3'b001);
    ticks("rr3_blank_b", 1, 3'b000);
    req = 3'b000;                      // ignored until the last blank cycle
    ticks("blank_no_early", 1, 3'b000);
    req = 3'b111;
    ticks("rr3_blank_c", 1, 3'b000);
    ticks("rr3_show1", 6, 3'b010);
    ticks("rr3_blank_d", 3, 3'b000);
    ticks("rr3_show2b", 6, 3'b100);
    ticks("rr3_blank_e", 3, 3'b000);
    tick("rr3_show0b", 3'b001);

    // Asynchronous reset mid-show, then restart from idle with fresh pointer.
    tick("pre_reset_show", 3'b001);
    sys_rst_n = 1'b0;
    req = 3'b110;
    #1;
    check_now("async_reset", 3'b000);
    @(posedge sys_clk); #1;
    check_now("reset_hold_mid", 3'b000);
    sys_rst_n = 1'b1;
    tick("post_reset_src1", 3'b010);
    ticks("post_reset_hold", 2, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
